// File: rtl/reg_bank_sb_pkg.sv
// Shared ISA constants for the register bank, ALU and decode blocks.
// Widths and the hard-wired zero register index live here.
package reg_bank_sb_pkg;

  localparam int DW       = 32;
  localparam int NREG     = 32;
  localparam int AW       = $clog2(NREG);
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_bank_sb_scoreboard.sv
// Pending-result scoreboard: one bit per register, set by loads,
// cleared by writeback, and the read stall derived from it.
module reg_scoreboard #(
  parameter  int NREG = reg_bank_sb_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          pend_set_i,
  input  logic [AW-1:0] pend_addr_i,
  output logic          stall_o
);

  import reg_bank_sb_pkg::*;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic            rs_busy;
  logic            rt_busy;

  // Set is applied after clear so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en_i) begin
      pend_d[wr_addr_i] = 1'b0;
    end
    if (pend_set_i) begin
      pend_d[pend_addr_i] = 1'b1;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A writeback landing this cycle releases its register immediately.
  assign rs_busy = (rs_addr_i != AW'(REG_ZERO))
                 && pend_q[rs_addr_i]
                 && !(wr_en_i && (wr_addr_i == rs_addr_i));
  assign rt_busy = (rt_addr_i != AW'(REG_ZERO))
                 && pend_q[rt_addr_i]
                 && !(wr_en_i && (wr_addr_i == rt_addr_i));

  assign stall_o = rd_en_i && (rs_busy || rt_busy);

endmodule

// File: rtl/reg_bank_sb.sv
// Two-read, one-write register bank with registered read data,
// write-through bypass and a load scoreboard that stalls reads.
module reg_bank_sb #(
  parameter  int DW   = reg_bank_sb_pkg::DW,
  parameter  int NREG = reg_bank_sb_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          pend_set,
  input  logic [AW-1:0] pend_addr,
  output logic          stall
);

  import reg_bank_sb_pkg::*;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rs_data_d;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] rt_data_d;
  logic          rd_valid_q;
  logic          accept;
  logic          rs_zero;
  logic          rt_zero;
  logic          rs_hit;
  logic          rt_hit;
  logic          wr_ok;

  reg_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en_i     (rd_en),
    .rs_addr_i   (rs_addr),
    .rt_addr_i   (rt_addr),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .pend_set_i  (pend_set),
    .pend_addr_i (pend_addr),
    .stall_o     (stall)
  );

  assign accept  = rd_en && !stall;
  assign wr_ok   = wr_en && (wr_addr != AW'(REG_ZERO));
  assign rs_zero = (rs_addr == AW'(REG_ZERO));
  assign rt_zero = (rt_addr == AW'(REG_ZERO));
  assign rs_hit  = wr_ok && (wr_addr == rs_addr);
  assign rt_hit  = wr_ok && (wr_addr == rt_addr);

  always_comb begin
    rs_data_d = rs_data_q;
    if (accept) begin
      unique case (1'b1)
        rs_zero: rs_data_d = '0;
        rs_hit:  rs_data_d = wr_data;
        default: rs_data_d = regs_q[rs_addr];
      endcase
    end
  end

  always_comb begin
    rt_data_d = rt_data_q;
    if (accept) begin
      unique case (1'b1)
        rt_zero: rt_data_d = '0;
        rt_hit:  rt_data_d = wr_data;
        default: rt_data_d = regs_q[rt_addr];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      rd_valid_q <= accept;
    end
  end

  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: array/scoreboard model checked every
// falling edge, plus directed scenarios with literal expectations.
module tb_reg_bank_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          pend_set = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic          stall;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  reg_bank_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays of register values and pending flags.
  logic [DW-1:0] m_mem [NR];
  bit            m_pend [NR];
  logic [DW-1:0] m_rs;
  logic [DW-1:0] m_rt;
  bit            m_valid;

  function automatic bit m_blocked(input int a);
    if (a == 0) return 1'b0;
    if (wr_en && int'(wr_addr) == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit m_stall();
    return rd_en && (m_blocked(int'(rs_addr)) || m_blocked(int'(rt_addr)));
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
      m_rs    <= '0;
      m_rt    <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= rd_en && !m_stall();
      if (rd_en && !m_stall()) begin
        m_rs <= m_read(int'(rs_addr));
        m_rt <= m_read(int'(rt_addr));
      end
      if (wr_en && wr_addr != 0) m_mem[wr_addr] <= wr_data;
      if (wr_en) m_pend[wr_addr] <= 1'b0;
      if (pend_set && pend_addr != 0) m_pend[pend_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      check("mdl_rd_valid", DW'(rd_valid), DW'(m_valid));
      check("mdl_rs_data", rs_data, m_rs);
      check("mdl_rt_data", rt_data, m_rt);
      check("mdl_stall", DW'(stall), DW'(m_stall()));
    end
  end

  task automatic step(input bit rd, input int rs, input int rt,
                      input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit ps, input int pa);
    @(posedge clk);
    #2;
    rd_en     = rd;
    rs_addr   = AW'(rs);
    rt_addr   = AW'(rt);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    pend_set  = ps;
    pend_addr = AW'(pa);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_valid", DW'(rd_valid), '0);
    check("rst_rs_data", rs_data, '0);
    rst_n = 1'b1;

    // Fresh read of arbitrary registers returns zero.
    step(1, 5, 9, 0, 0, '0, 0, 0);
    idle();
    check("r5_zero", rs_data, '0);
    check("r9_zero", rt_data, '0);
    check("r5r9_valid", DW'(rd_valid), 32'd1);

    step(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
    step(1, 7, 0, 0, 0, '0, 0, 0);
    idle();
    check("r7_data", rs_data, 32'hDEADBEEF);
    check("r0_rt", rt_data, '0);

    step(0, 0, 0, 1, 0, 32'h1234, 0, 0);
    step(1, 0, 7, 0, 0, '0, 0, 0);
    idle();
    check("r0_write_dropped", rs_data, '0);
    check("r7_still", rt_data, 32'hDEADBEEF);

    // Same-cycle write and read of r3.
    step(1, 1, 3, 1, 3, 32'hA5A5A5A5, 0, 0);
    idle();
    check("bypass_r3", rt_data, 32'hA5A5A5A5);
    check("bypass_rs_r1", rs_data, '0);

    // Pending r4: stall until writeback, which also clears it.
    step(0, 0, 0, 0, 0, '0, 1, 4);
    step(1, 4, 0, 0, 0, '0, 0, 0);
    #1 check("r4_stall", DW'(stall), 32'd1);
    step(1, 4, 0, 1, 4, 32'h55, 0, 0);
    #1 check("r4_release", DW'(stall), '0);
    idle();
    check("r4_data", rs_data, 32'h55);
    check("r4_valid", DW'(rd_valid), 32'd1);

    // Set wins over same-address clear.
    step(0, 0, 0, 1, 6, 32'h11, 1, 6);
    step(1, 0, 6, 0, 0, '0, 0, 0);
    #1 check("r6_stall", DW'(stall), 32'd1);
    step(1, 0, 6, 0, 0, '0, 0, 0);
    #1 check("r6_stall_held", DW'(stall), 32'd1);
    check("r6_no_valid", DW'(rd_valid), '0);
    step(1, 0, 6, 1, 6, 32'h22, 0, 0);
    #1 check("r6_release", DW'(stall), '0);
    idle();
    check("r6_data", rt_data, 32'h22);

    // Reset in the middle of traffic with r4 pending.
    step(0, 0, 0, 0, 0, '0, 1, 4);
    step(1, 7, 3, 0, 0, '0, 0, 0);
    idle();
    check("pre_rst_r7", rs_data, 32'hDEADBEEF);
    step(1, 4, 7, 0, 0, '0, 0, 0);
    #1 check("pre_rst_stall", DW'(stall), 32'd1);
    step(1, 7, 3, 0, 0, '0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rs", rs_data, '0);
    check("mid_rst_valid", DW'(rd_valid), '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 4, 7, 0, 0, '0, 0, 0);
    #1 check("post_rst_nostall", DW'(stall), '0);
    idle();
    check("post_rst_r4", rs_data, '0);
    check("post_rst_r7", rt_data, '0);
    check("post_rst_valid", DW'(rd_valid), 32'd1);
    idle();
    idle();

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
